// File: rtl/upload_req_arb_pkg.sv
// upload_req_arb_pkg
// Shared definitions for the upload request arbiter: FSM state encodings,
// the "no grant" code, default packet lengths per requester and a small
// modulo-3 port-index helper.
package upload_req_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] ARB_NONE       = 2'b11;
  localparam logic [1:0] LAST_GRANT_RST = 2'd2;

  localparam int DC_REQ_LEN   = 3;
  localparam int IC_REQ_LEN   = 3;
  localparam int CTRL_REQ_LEN = 1;

  // Port after p, wrapping 2 -> 0; the unused code 3 also maps to 0
  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/upload_req_arb_rr_pick3.sv
// rr_pick3
// Stateless three-way requester selection. The search starts at the port
// after last_grant and wraps modulo 3; the first requesting port wins.
// Ports:
//   req        in  [2:0]  request vector, bit N = port N
//   last_grant in  [1:0]  most recently granted port (0..2)
//   winner     out [1:0]  selected port, ARB_NONE when nothing requests
module rr_pick3
  import upload_req_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  logic [1:0] p0;
  logic [1:0] p1;
  logic [1:0] p2;

  // Evaluate lowest priority first so later matches override earlier ones
  always_comb begin
    p0     = next_port(last_grant);
    p1     = next_port(p0);
    p2     = next_port(p1);
    winner = ARB_NONE;
    if (req[p2]) winner = p2;
    if (req[p1]) winner = p1;
    if (req[p0]) winner = p0;
  end

endmodule

// File: rtl/upload_req_arb.sv
// upload_req_arb
// Arbitrates three packet requesters (dcache, icache, local ctrl) onto one
// downstream request FIFO. An IDLE cycle picks a winner, then BUSY passes
// the winner's flits straight through until its packet length is reached.
// Config macro: UPLOAD_ARB_RR_EN defined -> round-robin; undefined ->
// fixed priority 0>1>2 (last_grant still tracked).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fifo_rdy                  downstream FIFO accepts a flit this cycle
//   v_flit_in0..2, flit_in0..2 requester flit valid / data
//   rdy_out0..2               per-requester ready
//   flit_out, v_flit_out      flit to the FIFO and its valid
//   arb_busy                  packet in progress
//   arb_grant                 granted port, 2'b11 when none
module upload_req_arb
  import upload_req_arb_pkg::*;
#(
  parameter int LEN0 = DC_REQ_LEN,
  parameter int LEN1 = IC_REQ_LEN,
  parameter int LEN2 = CTRL_REQ_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rdy,
  input  logic        v_flit_in0,
  input  logic        v_flit_in1,
  input  logic        v_flit_in2,
  input  logic [15:0] flit_in0,
  input  logic [15:0] flit_in1,
  input  logic [15:0] flit_in2,
  output logic        rdy_out0,
  output logic        rdy_out1,
  output logic        rdy_out2,
  output logic [15:0] flit_out,
  output logic        v_flit_out,
  output logic        arb_busy,
  output logic [1:0]  arb_grant
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic [1:0]  grant_q;
  logic [1:0]  last_grant;
  logic [1:0]  flit_cnt;
  logic [1:0]  pick_last;
  logic [1:0]  winner;
  logic [1:0]  cur_len_m1;
  logic [2:0]  req_vec;
  logic        sel_v;
  logic [15:0] sel_flit;
  logic        beat;
  logic        pkt_done;

  assign req_vec = {v_flit_in2, v_flit_in1, v_flit_in0};

  // Fixed priority reuses the rotating picker with the search pinned to port 0
`ifdef UPLOAD_ARB_RR_EN
  assign pick_last = last_grant;
`else
  assign pick_last = LAST_GRANT_RST;
`endif

  rr_pick3 u_pick (
    .req        (req_vec),
    .last_grant (pick_last),
    .winner     (winner)
  );

  always_comb begin
    sel_v      = 1'b0;
    sel_flit   = 16'h0000;
    cur_len_m1 = 2'(LEN0 - 1);
    case (grant_q)
      2'd0: begin
        sel_v      = v_flit_in0;
        sel_flit   = flit_in0;
        cur_len_m1 = 2'(LEN0 - 1);
      end
      2'd1: begin
        sel_v      = v_flit_in1;
        sel_flit   = flit_in1;
        cur_len_m1 = 2'(LEN1 - 1);
      end
      2'd2: begin
        sel_v      = v_flit_in2;
        sel_flit   = flit_in2;
        cur_len_m1 = 2'(LEN2 - 1);
      end
      default: ;
    endcase
  end

  assign beat     = (state == ST_BUSY) && sel_v && fifo_rdy;
  assign pkt_done = beat && (flit_cnt == cur_len_m1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req_vec) state_nxt = ST_BUSY;
      ST_BUSY: if (pkt_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Zero-cycle pass-through of the granted requester while BUSY
  always_comb begin
    rdy_out0   = 1'b0;
    rdy_out1   = 1'b0;
    rdy_out2   = 1'b0;
    flit_out   = 16'h0000;
    v_flit_out = 1'b0;
    if (state == ST_BUSY) begin
      case (grant_q)
        2'd0:    rdy_out0 = fifo_rdy;
        2'd1:    rdy_out1 = fifo_rdy;
        2'd2:    rdy_out2 = fifo_rdy;
        default: ;
      endcase
      flit_out   = sel_flit;
      v_flit_out = sel_v & fifo_rdy;
    end
  end

  assign arb_busy  = (state == ST_BUSY);
  assign arb_grant = grant_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // grant_q holds ARB_NONE whenever IDLE, so it drives arb_grant directly
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= ARB_NONE;
      last_grant <= LAST_GRANT_RST;
      flit_cnt   <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_vec) grant_q <= winner;
        end
        ST_BUSY: begin
          if (pkt_done) begin
            flit_cnt   <= 2'd0;
            last_grant <= grant_q;
            grant_q    <= ARB_NONE;
          end else if (beat) begin
            flit_cnt <= flit_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // last_grant only ever holds a real port index
  a_last_grant_valid: assert property (@(posedge clk) disable iff (rst)
    last_grant != ARB_NONE);

endmodule

// File: doc/upload_req_arb.md
UPLOAD_REQ_ARB -- requirements
Module: upload_req_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LEN0, 3, flits per packet on port 0 (dcache req); LEN1, 3, flits per packet on port 1 (icache req); LEN2, 1, flits per packet on port 2 (local ctrl req); each is legal only in range 1..3.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; rst, in, 1, reset, synchronous, active-high
- fifo_rdy, in, 1, downstream request FIFO can accept a flit this cycle
- v_flit_in0 / v_flit_in1 / v_flit_in2, in, 1 each, requester flit valid
- flit_in0 / flit_in1 / flit_in2, in, 16 each, requester flit
- rdy_out0 / rdy_out1 / rdy_out2, out, 1 each, per-requester ready (requester's fifo_rdy)
- flit_out, out, 16, flit to request FIFO
- v_flit_out, out, 1, flit_out valid
- arb_busy, out, 1, packet in progress
- arb_grant, out, 2, granted port (2'b11 = none)

Function
REQ-003 FSM SHALL have exactly two states, IDLE (arb_busy=0) and BUSY (arb_busy=1).
REQ-004 In IDLE, if any v_flit_inN=1, the block SHALL register the winner into arb_grant and move to BUSY next cycle; no flit transfers in the IDLE cycle.
REQ-005 Winner selection SHALL be round-robin: search starts at the port after last_grant (0→1→2→0); last_grant resets to 2, so the first search starts at port 0.
REQ-006 In BUSY, rdy_out[g]=fifo_rdy, all other rdy_out=0, flit_out=flit_in[g], and v_flit_out=v_flit_in[g]&fifo_rdy, all combinational (zero-cycle pass-through).
REQ-007 A beat SHALL occur when v_flit_in[g]&fifo_rdy=1; each beat increments a 2-bit flit counter.
REQ-008 On the beat where counter==LEN[g]-1, the block SHALL return to IDLE, clear the counter, and set last_grant<=g.
REQ-009 Grant SHALL be held for the whole packet; v_flit_in toggling or fifo_rdy=0 stalls without losing the count.
REQ-010 In IDLE, outputs SHALL be: rdy_out*=0, v_flit_out=0, flit_out=16'h0000, arb_grant=2'b11.
REQ-011 A request arriving on the same cycle a packet ends SHALL be arbitrated in the following IDLE cycle, giving a minimum 1-cycle gap between packets.
REQ-012 Port-index arithmetic SHALL wrap modulo 3; value 2'b11 SHALL never be stored as last_grant.

Reset
REQ-013 rst SHALL take priority over all events, including mid-packet, and SHALL force: state=IDLE, counter=0, last_grant=2, arb_grant=2'b11, and every output to its IDLE value from the next cycle.
REQ-014 A packet aborted by reset SHALL NOT be resumed; the requester is expected to be reset concurrently.

Configuration
REQ-015 Macro UPLOAD_ARB_RR_EN SHALL select the arbitration policy: defined gives round-robin per REQ-005; undefined gives fixed priority 0>1>2, with last_grant still maintained but unused.

Structure
REQ-016 A shared package SHALL hold: the FSM state encodings, the ARB_NONE=2'b11 constant, and the default packet-length constants (DC_REQ_LEN=3, IC_REQ_LEN=3, CTRL_REQ_LEN=1).
REQ-017 Requester selection SHALL be a sub-module rr_pick3 (inputs: 3-bit request vector and last_grant; output: 2-bit winner); it contains no state.

Verification
REQ-018 Single request: port 0 valid, fifo_rdy=1, LEN0=3 -> arb_grant=0 at cycle 1; three beats on cycles 1-3 carrying flit_in0; IDLE at cycle 4.
REQ-019 Contention, RR build: ports 0/1/2 requesting continuously -> grant order 0,1,2,0, with a 1-cycle IDLE gap after each packet.
REQ-020 Back-pressure: fifo_rdy=0 for 5 cycles after the 1st beat -> v_flit_out=0 and counter held at 1; exactly 2 more beats complete the packet after fifo_rdy returns.
REQ-021 Reset mid-packet: rst on the 2nd beat -> next cycle arb_busy=0, arb_grant=2'b11, all rdy_out=0; the next grant goes to port 0.
REQ-022 Fixed-priority build (macro undefined): all ports requesting -> port 0 always wins; port 2 granted only once ports 0 and 1 drop.
REQ-023 LEN2=1: port 2 alone -> a single beat, then IDLE; flit_out equals flit_in2 on that beat.
